// File: rtl/fifo_csr_regs.sv
// fifo_csr_regs
//   AXI4-Lite-style CSR slave and register file that controls and monitors a
//   single FIFO instance. All logic runs on csr_clk; FIFO status inputs are
//   expected to be synchronous to csr_clk already.
//
// Ports
//   csr_clk, csr_resetn        clock, asynchronous active-low reset
//   csr_aw*/csr_w*/csr_b*      write address / data / response channels
//   csr_ar*/csr_r*             read address / data channels (single beat)
//   fifo_empty/full/level      FIFO status
//   fifo_wr/rd_attempt         access requests seen by the FIFO this cycle
//   fifo_flush, fifo_enable    FIFO controls
//   irq                        level interrupt, |(EVT & IRQ_MASK), registered
//
// Register map (word addresses)
//   0x0 CTRL  RW   bit0 write 1 = start flush (reads 1 while active), bit1 enable
//   0x1 STATUS RO  bit0 empty, bit1 full, bit2 almost_empty, bit3 almost_full
//   0x2 LEVEL RO   fifo_level
//   0x3 AF_THRESH RW, 0x4 AE_THRESH RW
//   0x5 EVT   RW1C bit0 overflow, bit1 underflow, bit2 almost_full rise
//   0x6 IRQ_MASK RW [2:0]
module fifo_csr_regs #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int LEVEL_WIDTH  = 9,
    parameter int FLUSH_CYCLES = 4,
    parameter int AF_DEFAULT   = 200,
    parameter int AE_DEFAULT   = 8
) (
    input  logic                   csr_clk,
    input  logic                   csr_resetn,
    input  logic [ADDR_WIDTH-1:0]  csr_awaddr,
    input  logic                   csr_awvalid,
    output logic                   csr_awready,
    input  logic [DATA_WIDTH-1:0]  csr_wdata,
    input  logic                   csr_wvalid,
    output logic                   csr_wready,
    output logic [1:0]             csr_bresp,
    output logic                   csr_bvalid,
    input  logic                   csr_bready,
    input  logic [ADDR_WIDTH-1:0]  csr_araddr,
    input  logic                   csr_arvalid,
    output logic                   csr_arready,
    output logic [DATA_WIDTH-1:0]  csr_rdata,
    output logic [1:0]             csr_rresp,
    output logic                   csr_rvalid,
    input  logic                   csr_rready,
    output logic                   csr_rlast,
    input  logic                   fifo_empty,
    input  logic                   fifo_full,
    input  logic [LEVEL_WIDTH-1:0] fifo_level,
    input  logic                   fifo_wr_attempt,
    input  logic                   fifo_rd_attempt,
    output logic                   fifo_flush,
    output logic                   fifo_enable,
    output logic                   irq
);

    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CNT_W-1:0]       FLUSH_LOAD = CNT_W'(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0]       CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [ADDR_WIDTH-1:0]  A_CTRL     = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0]  A_STATUS   = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0]  A_LEVEL    = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0]  A_AF       = ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0]  A_AE       = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0]  A_EVT      = ADDR_WIDTH'(5);
    localparam logic [ADDR_WIDTH-1:0]  A_MASK     = ADDR_WIDTH'(6);
    localparam logic [1:0]             RESP_OKAY   = 2'b00;
    localparam logic [1:0]             RESP_SLVERR = 2'b10;

    typedef enum logic [0:0] {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_e;
    typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

    // write channel state
    w_state_e               w_state_q, w_state_d;
    logic                   awready_q, awready_d;
    logic                   wready_q, wready_d;
    logic [ADDR_WIDTH-1:0]  awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic                   bvalid_q, bvalid_d;
    logic [1:0]             bresp_q, bresp_d;
    // read channel state
    r_state_e               r_state_q, r_state_d;
    logic                   arready_q, arready_d;
    logic                   rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic [1:0]             rresp_q, rresp_d;
    // register file
    logic                   enable_q, enable_d;
    logic [CNT_W-1:0]       flush_cnt_q, flush_cnt_d;
    logic                   flush_q, flush_d;
    logic [LEVEL_WIDTH-1:0] af_th_q, af_th_d;
    logic [LEVEL_WIDTH-1:0] ae_th_q, ae_th_d;
    logic [2:0]             evt_q, evt_d;
    logic [2:0]             mask_q, mask_d;
    logic                   irq_q, irq_d;
    logic                   af_q, af_d;
    logic                   af_valid_q, af_valid_d;

    logic                   aw_hs_s, w_hs_s, have_aw_s, have_w_s;
    logic                   wr_commit_s, wr_ok_s;
    logic [ADDR_WIDTH-1:0]  wr_addr_s;
    logic [DATA_WIDTH-1:0]  wr_data_s;
    logic                   almost_full_s, almost_empty_s;
    logic [2:0]             evt_set_s, evt_clr_s;
    logic [CNT_W-1:0]       flush_dec_s;
    logic [DATA_WIDTH-1:0]  rd_data_s;
    logic                   rd_ok_s;
    logic                   unused_wdata_s;

    // Readies are only high in W_IDLE, so a low ready there means the beat is held.
    assign aw_hs_s   = csr_awvalid & awready_q;
    assign w_hs_s    = csr_wvalid & wready_q;
    assign have_aw_s = ~awready_q | csr_awvalid;
    assign have_w_s  = ~wready_q | csr_wvalid;
    assign wr_addr_s = awready_q ? csr_awaddr : awaddr_q;
    assign wr_data_s = wready_q ? csr_wdata : wdata_q;
    assign unused_wdata_s = ^wr_data_s;

    assign almost_full_s  = (fifo_level >= af_th_q);
    assign almost_empty_s = (fifo_level <= ae_th_q);
    assign flush_dec_s    = (flush_cnt_q != CNT_ZERO) ? (flush_cnt_q - CNT_W'(1)) : CNT_ZERO;
    // af rise compares the registered flag against the live compare; af_valid_q
    // masks the very first edge out of reset.
    assign evt_set_s = {af_valid_q & almost_full_s & ~af_q,
                        fifo_empty & fifo_rd_attempt,
                        fifo_full & fifo_wr_attempt};

    // Write address decode: writable registers answer OKAY, everything else SLVERR.
    always_comb begin
        wr_ok_s = 1'b0;
        case (wr_addr_s)
            A_CTRL, A_AF, A_AE, A_EVT, A_MASK: wr_ok_s = 1'b1;
            default:                           wr_ok_s = 1'b0;
        endcase
    end

    // Write FSM: collect AW and W in any order, commit, then hold the response.
    always_comb begin
        w_state_d   = w_state_q;
        awready_d   = awready_q;
        wready_d    = wready_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        wr_commit_s = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs_s) begin
                    awaddr_d  = csr_awaddr;
                    awready_d = 1'b0;
                end else begin
                    awaddr_d  = awaddr_q;
                end
                if (w_hs_s) begin
                    wdata_d  = csr_wdata;
                    wready_d = 1'b0;
                end else begin
                    wdata_d  = wdata_q;
                end
                if (have_aw_s && have_w_s) begin
                    wr_commit_s = 1'b1;
                    awready_d   = 1'b0;
                    wready_d    = 1'b0;
                    bvalid_d    = 1'b1;
                    bresp_d     = wr_ok_s ? RESP_OKAY : RESP_SLVERR;
                    w_state_d   = W_RESP;
                end else begin
                    wr_commit_s = 1'b0;
                    w_state_d   = W_IDLE;
                end
            end
            W_RESP: begin
                if (csr_bready) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    w_state_d = W_IDLE;
                end else begin
                    bvalid_d  = 1'b1;
                    w_state_d = W_RESP;
                end
            end
            default: begin
                w_state_d = W_IDLE;
                awready_d = 1'b1;
                wready_d  = 1'b1;
                bvalid_d  = 1'b0;
            end
        endcase
    end

    // Register file update: committed writes, flush countdown, events, irq.
    always_comb begin
        enable_d    = enable_q;
        af_th_d     = af_th_q;
        ae_th_d     = ae_th_q;
        mask_d      = mask_q;
        flush_cnt_d = flush_dec_s;
        evt_clr_s   = 3'b000;
        if (wr_commit_s) begin
            case (wr_addr_s)
                A_CTRL: begin
                    enable_d = wr_data_s[1];
                    // Writing 0 to bit0 never cancels a running flush.
                    flush_cnt_d = wr_data_s[0] ? FLUSH_LOAD : flush_dec_s;
                end
                A_AF:    af_th_d   = wr_data_s[LEVEL_WIDTH-1:0];
                A_AE:    ae_th_d   = wr_data_s[LEVEL_WIDTH-1:0];
                A_EVT:   evt_clr_s = wr_data_s[2:0];
                A_MASK:  mask_d    = wr_data_s[2:0];
                default: evt_clr_s = 3'b000;
            endcase
        end else begin
            evt_clr_s = 3'b000;
        end
        // A new event in the same cycle as its W1C clear survives.
        evt_d      = (evt_q & ~evt_clr_s) | evt_set_s;
        flush_d    = (flush_cnt_d != CNT_ZERO);
        irq_d      = |(evt_q & mask_q);
        af_d       = almost_full_s;
        af_valid_d = 1'b1;
    end

    // Read data mux; unused bits read 0, unmapped addresses return 0.
    always_comb begin
        rd_data_s = {DATA_WIDTH{1'b0}};
        rd_ok_s   = 1'b1;
        case (csr_araddr)
            A_CTRL:   rd_data_s[1:0] = {enable_q, flush_q};
            A_STATUS: rd_data_s[3:0] = {almost_full_s, almost_empty_s, fifo_full, fifo_empty};
            A_LEVEL:  rd_data_s[LEVEL_WIDTH-1:0] = fifo_level;
            A_AF:     rd_data_s[LEVEL_WIDTH-1:0] = af_th_q;
            A_AE:     rd_data_s[LEVEL_WIDTH-1:0] = ae_th_q;
            A_EVT:    rd_data_s[2:0] = evt_q;
            A_MASK:   rd_data_s[2:0] = mask_q;
            default:  rd_ok_s = 1'b0;
        endcase
    end

    // Read FSM: capture on AR handshake, hold data until rready.
    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                if (csr_arvalid) begin
                    rdata_d   = rd_data_s;
                    rresp_d   = rd_ok_s ? RESP_OKAY : RESP_SLVERR;
                    rvalid_d  = 1'b1;
                    arready_d = 1'b0;
                    r_state_d = R_DATA;
                end else begin
                    r_state_d = R_IDLE;
                end
            end
            R_DATA: begin
                if (csr_rready) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    r_state_d = R_IDLE;
                end else begin
                    r_state_d = R_DATA;
                end
            end
            default: begin
                r_state_d = R_IDLE;
                arready_d = 1'b1;
                rvalid_d  = 1'b0;
            end
        endcase
    end

    // Write channel registers.
    always_ff @(posedge csr_clk or negedge csr_resetn) begin
        if (!csr_resetn) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            awaddr_q  <= {ADDR_WIDTH{1'b0}};
            wdata_q   <= {DATA_WIDTH{1'b0}};
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

    // Read channel registers.
    always_ff @(posedge csr_clk or negedge csr_resetn) begin
        if (!csr_resetn) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rdata_q   <= {DATA_WIDTH{1'b0}};
            rresp_q   <= 2'b00;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    // Control, threshold, event and interrupt registers.
    always_ff @(posedge csr_clk or negedge csr_resetn) begin
        if (!csr_resetn) begin
            enable_q    <= 1'b0;
            flush_cnt_q <= CNT_ZERO;
            flush_q     <= 1'b0;
            af_th_q     <= LEVEL_WIDTH'(AF_DEFAULT);
            ae_th_q     <= LEVEL_WIDTH'(AE_DEFAULT);
            evt_q       <= 3'b000;
            mask_q      <= 3'b000;
            irq_q       <= 1'b0;
            af_q        <= 1'b0;
            af_valid_q  <= 1'b0;
        end else begin
            enable_q    <= enable_d;
            flush_cnt_q <= flush_cnt_d;
            flush_q     <= flush_d;
            af_th_q     <= af_th_d;
            ae_th_q     <= ae_th_d;
            evt_q       <= evt_d;
            mask_q      <= mask_d;
            irq_q       <= irq_d;
            af_q        <= af_d;
            af_valid_q  <= af_valid_d;
        end
    end

    assign csr_awready = awready_q;
    assign csr_wready  = wready_q;
    assign csr_bvalid  = bvalid_q;
    assign csr_bresp   = bresp_q;
    assign csr_arready = arready_q;
    assign csr_rvalid  = rvalid_q;
    assign csr_rlast   = rvalid_q;
    assign csr_rdata   = rdata_q;
    assign csr_rresp   = rresp_q;
    assign fifo_flush  = flush_q;
    assign fifo_enable = enable_q;
    assign irq         = irq_q;

endmodule
